vga_controller: RTL and testbench
=================================

VGA_CONTROLLER -- requirements
Module: vga_controller

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 The block SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, meaning horizontal front porch, sync and back porch widths in clocks.
REQ-003 The block SHALL have parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-004 The block SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, meaning vertical front porch, sync and back porch heights in lines.
REQ-005 The block SHALL have parameter RGB_LATENCY, default 2, range 0..7, meaning clocks from a pixelX/pixelY change to the matching colour at Red/Green/Blue_level.
REQ-006 The block SHALL have port clk, input, 1 bit: pixel clock (25.175/25 MHz), the only clock.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have ports Red_level, Green_level, Blue_level, each input, 4 bits: colour returned by the drawing chain.
REQ-009 The block SHALL have ports pixelX and pixelY, each output, 11 bits: current horizontal and vertical counters, sent to the object drawers.
REQ-010 The block SHALL have port startOfFrame, output, 1 bit: one-clock pulse that marks the first clock of vertical blanking.
REQ-011 The block SHALL have ports vga_r, vga_g, vga_b, each output, 4 bits: DAC colour.
REQ-012 The block SHALL have ports hsync and vsync, each output, 1 bit: active-low sync.

Function
REQ-013 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP (800), and V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-014 The horizontal counter SHALL increment every clk, and it SHALL wrap from H_TOTAL-1 to 0.
REQ-015 The vertical counter SHALL increment only on a horizontal wrap, and it SHALL wrap from V_TOTAL-1 to 0 when it and the horizontal counter wrap in the same clock.
REQ-016 pixelX and pixelY SHALL be the registered counters themselves, covering the full range including blanking (0..799, 0..524).
REQ-017 Raw active SHALL be asserted when hcount<H_ACTIVE and vcount<V_ACTIVE.
REQ-018 Raw hsync SHALL be 0 when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751) and 1 otherwise.
REQ-019 Raw vsync SHALL be 0 when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491) and 1 otherwise.
REQ-020 Raw active, hsync and vsync SHALL pass through an RGB_LATENCY-stage shift register; with RGB_LATENCY=0 the shift register SHALL be a direct connection.
REQ-021 Output registers SHALL sample in each clk: hsync/vsync from the delayed raw values, and vga_r/g/b from Red/Green/Blue_level when the delayed active is 1, else 4'h0.
REQ-022 Total latency from a counter value (h,v) to the hsync/vsync/vga_* values for (h,v) SHALL be RGB_LATENCY+1 clocks.
REQ-023 Colour SHALL be forced to 0 in every blanking clock regardless of the input levels.
REQ-024 startOfFrame SHALL be registered and SHALL be high for exactly the clock in which pixelY==V_ACTIVE and pixelX==0, and low otherwise (one pulse per frame).
REQ-025 Counters SHALL produce no gaps, repeats or stalls, so every frame is exactly H_TOTAL*V_TOTAL = 420000 clocks.

Reset
REQ-026 While reset=1, pixelX=0, pixelY=0, startOfFrame=0, hsync=1, vsync=1, and vga_r/g/b=0.
REQ-027 While reset=1, every delay-line stage SHALL hold active=0, hsync=1, vsync=1.
REQ-028 Reset asserted mid-frame SHALL take effect asynchronously.
REQ-029 After reset is released, the first clk edge SHALL advance pixelX to 1, so counting restarts from (0,0) with no spurious sync or colour.

Verification
REQ-030 Release reset, run 420000 clocks -> exactly one startOfFrame pulse, at pixelX=0/pixelY=480, clock 384000 after release; pixelX/pixelY back at (0,0) at clock 420000.
REQ-031 Drive Red/Green/Blue_level as a function of the delayed pixelX, RGB_LATENCY=2 -> vga_r equals the level for (h,v) exactly 3 clocks after pixelX=h, with zero skew against hsync.
REQ-032 Hold Red/Green/Blue_level=4'hF constantly -> vga_r/g/b is F for 640 clocks per line on lines 0..479 and 0 in all other clocks.
REQ-033 Measure sync over one frame -> hsync low for 96 clocks starting 656 clocks into each line, and vsync low for exactly 2 lines (1600 clocks) starting at line 490.
REQ-034 Assert reset at pixelX=300/pixelY=200 for 5 clocks -> outputs are at reset values immediately, with no delayed colour emerging after release, and counting restarts from (0,0).
REQ-035 Set RGB_LATENCY=0 and apply Red_level=4'hA at pixelX=5/pixelY=0 -> vga_r=4'hA on the next clock.

Source files
------------

// File: rtl/vga_controller.sv
// VGA timing generator with a matched-latency colour path.
//
// Free-running horizontal/vertical counters are exported as pixelX/pixelY to the
// object drawers. The drawing chain answers with a colour RGB_LATENCY clocks later;
// the raw active/hsync/vsync flags are delayed by the same amount so that colour and
// sync leave the final output registers aligned (total latency RGB_LATENCY+1).
//
// Ports:
//   clk                       pixel clock, the only clock
//   reset                     asynchronous, active-high
//   Red/Green/Blue_level      4-bit colour returned by the drawing chain
//   pixelX, pixelY            11-bit counters, full range including blanking
//   startOfFrame              one-clock pulse at the first clock of vertical blanking
//   vga_r, vga_g, vga_b       4-bit DAC colour, forced to 0 during blanking
//   hsync, vsync              active-low sync
module vga_controller #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned RGB_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  Red_level,
  input  logic [3:0]  Green_level,
  input  logic [3:0]  Blue_level,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync
);

  localparam logic [10:0] HAct      = 11'(H_ACTIVE);
  localparam logic [10:0] HSyncBeg  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HSyncEnd  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] HTotal    = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [10:0] VAct      = 11'(V_ACTIVE);
  localparam logic [10:0] VSyncBeg  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VSyncEnd  = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] VTotal    = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        sof_q, sof_d;
  logic        raw_active, raw_hsync, raw_vsync;
  logic        dly_active, dly_hsync, dly_vsync;
  logic        hsync_q, vsync_q;
  logic [3:0]  r_q, g_q, b_q;

  // Counters: vertical advances only on the horizontal wrap.
  always_comb begin
    hcount_d = hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (hcount_q == HTotal - 11'd1) begin
      hcount_d = 11'd0;
      vcount_d = (vcount_q == VTotal - 11'd1) ? 11'd0 : vcount_q + 11'd1;
    end
  end

  // startOfFrame is registered from the next-state counters so it is high in
  // exactly the clock where the counters read (0, V_ACTIVE).
  assign sof_d = (hcount_d == 11'd0) && (vcount_d == VAct);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount_q <= 11'd0;
      vcount_q <= 11'd0;
      sof_q    <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      sof_q    <= sof_d;
    end
  end

  assign raw_active = (hcount_q < HAct) && (vcount_q < VAct);
  assign raw_hsync  = !((hcount_q >= HSyncBeg) && (hcount_q < HSyncEnd));
  assign raw_vsync  = !((vcount_q >= VSyncBeg) && (vcount_q < VSyncEnd));

  // Delay line matching the drawing-chain latency; reset to blanking values so no
  // stale colour or sync can emerge after reset is released.
  if (RGB_LATENCY == 0) begin : g_no_dly
    assign dly_active = raw_active;
    assign dly_hsync  = raw_hsync;
    assign dly_vsync  = raw_vsync;
  end else begin : g_dly
    logic [RGB_LATENCY-1:0] act_q, hs_q, vs_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        act_q <= '0;
        hs_q  <= '1;
        vs_q  <= '1;
      end else begin
        act_q[0] <= raw_active;
        hs_q[0]  <= raw_hsync;
        vs_q[0]  <= raw_vsync;
        for (int i = 1; i < RGB_LATENCY; i++) begin
          act_q[i] <= act_q[i-1];
          hs_q[i]  <= hs_q[i-1];
          vs_q[i]  <= vs_q[i-1];
        end
      end
    end

    assign dly_active = act_q[RGB_LATENCY-1];
    assign dly_hsync  = hs_q[RGB_LATENCY-1];
    assign dly_vsync  = vs_q[RGB_LATENCY-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      r_q     <= 4'h0;
      g_q     <= 4'h0;
      b_q     <= 4'h0;
    end else begin
      hsync_q <= dly_hsync;
      vsync_q <= dly_vsync;
      r_q     <= dly_active ? Red_level   : 4'h0;
      g_q     <= dly_active ? Green_level : 4'h0;
      b_q     <= dly_active ? Blue_level  : 4'h0;
    end
  end

  assign pixelX       = hcount_q;
  assign pixelY       = vcount_q;
  assign startOfFrame = sof_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign vga_r        = r_q;
  assign vga_g        = g_q;
  assign vga_b        = b_q;

endmodule

// File: tb/tb_vga_controller.sv
// Bench for vga_controller using reduced timing (25 x 17 clock frame). A bench-side
// model of the counters feeds a scoreboard of expected {hsync, vsync, rgb} entries,
// popped RGB_LATENCY+1 clocks later. A second instance with RGB_LATENCY=0 checks the
// one-clock path.
module tb_vga_controller;

  localparam int HA = 16, HFP = 2, HS = 3, HBP = 4;
  localparam int VA = 10, VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int L  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  Red_level = 4'h0, Green_level = 4'h0, Blue_level = 4'h0;
  logic [10:0] pixelX, pixelY;
  logic        startOfFrame, hsync, vsync;
  logic [3:0]  vga_r, vga_g, vga_b;

  logic [3:0]  red0 = 4'h0, green0 = 4'h0, blue0 = 4'h0;
  logic [10:0] pixelX0, pixelY0;
  logic        sof0, hsync0, vsync0;
  logic [3:0]  vga_r0, vga_g0, vga_b0;

  vga_controller #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .RGB_LATENCY(L)
  ) dut (
    .clk(clk), .reset(reset),
    .Red_level(Red_level), .Green_level(Green_level), .Blue_level(Blue_level),
    .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(startOfFrame),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .hsync(hsync), .vsync(vsync)
  );

  vga_controller #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .RGB_LATENCY(0)
  ) dut0 (
    .clk(clk), .reset(reset),
    .Red_level(red0), .Green_level(green0), .Blue_level(blue0),
    .pixelX(pixelX0), .pixelY(pixelY0), .startOfFrame(sof0),
    .vga_r(vga_r0), .vga_g(vga_g0), .vga_b(vga_b0), .hsync(hsync0), .vsync(vsync0)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int h_m, v_m, n_cyc;
  int sof_cnt, sof_at, hs_low, vs_low, full_cnt;
  logic mode_f;
  logic [13:0] exp_q[$];
  logic [11:0] drv_q[$];
  logic        p0_act, p0_hs, p0_vs, p0_mark;
  logic [11:0] p0_rgb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic hs_raw(input int h);
    return !(h >= HA + HFP && h < HA + HFP + HS);
  endfunction

  function automatic logic vs_raw(input int v);
    return !(v >= VA + VFP && v < VA + VFP + VS);
  endfunction

  function automatic logic [11:0] pat(input int h, input int v);
    logic [3:0] hh, vv;
    hh = 4'(h);
    vv = 4'(v);
    return {1'b1, hh[2:0], vv ^ 4'h5, hh + vv};
  endfunction

  task automatic reinit();
    h_m = 0; v_m = 0; n_cyc = 0;
    exp_q.delete();
    drv_q.delete();
    repeat (L + 1) exp_q.push_back({2'b11, 12'h000});
    repeat (L) drv_q.push_back(12'h000);
    p0_act = 1'b0; p0_hs = 1'b1; p0_vs = 1'b1; p0_mark = 1'b0; p0_rgb = 12'h000;
  endtask

  task automatic clear_stats();
    sof_cnt = 0; sof_at = -1; hs_low = 0; vs_low = 0; full_cnt = 0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_px"}, 32'(pixelX), 32'd0);
    check({tag, "_py"}, 32'(pixelY), 32'd0);
    check({tag, "_sof"}, 32'(startOfFrame), 32'd0);
    check({tag, "_hs"}, 32'(hsync), 32'd1);
    check({tag, "_vs"}, 32'(vsync), 32'd1);
    check({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
    check({tag, "_rgb0"}, 32'({vga_r0, vga_g0, vga_b0}), 32'd0);
  endtask

  // Called at a falling edge: compare, then drive the next inputs, then wait a clock.
  task automatic do_cycle();
    logic [13:0] e;
    logic [11:0] lvl, drv, lvl0;
    logic        act;
    check("pixelX", 32'(pixelX), 32'(h_m));
    check("pixelY", 32'(pixelY), 32'(v_m));
    check("sof", 32'(startOfFrame), 32'(h_m == 0 && v_m == VA));
    e = exp_q.pop_front();
    check("hsync", 32'(hsync), 32'(e[13]));
    check("vsync", 32'(vsync), 32'(e[12]));
    check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e[11:0]));
    check("lat0_px", 32'(pixelX0), 32'(h_m));
    check("lat0_sof", 32'(sof0), 32'(h_m == 0 && v_m == VA));
    check("lat0_rgb", 32'({vga_r0, vga_g0, vga_b0}), 32'(p0_act ? p0_rgb : 12'h000));
    check("lat0_hs", 32'(hsync0), 32'(p0_hs));
    check("lat0_vs", 32'(vsync0), 32'(p0_vs));
    if (p0_mark) check("lat0_A", 32'(vga_r0), 32'h0000000A);

    if (startOfFrame) begin
      sof_cnt++;
      if (sof_at < 0) sof_at = n_cyc;
    end
    if (!hsync) hs_low++;
    if (!vsync) vs_low++;
    if ({vga_r, vga_g, vga_b} == 12'hFFF) full_cnt++;

    act = (h_m < HA) && (v_m < VA);
    lvl = mode_f ? 12'hFFF : pat(h_m, v_m);
    exp_q.push_back({hs_raw(h_m), vs_raw(v_m), act ? lvl : 12'h000});
    drv_q.push_back(lvl);
    drv = drv_q.pop_front();
    {Red_level, Green_level, Blue_level} = drv;

    lvl0 = {((h_m == 5 && v_m == 0) ? 4'hA : 4'h3), 4'h5, 4'hC};
    {red0, green0, blue0} = lvl0;
    p0_act  = act;
    p0_rgb  = lvl0;
    p0_hs   = hs_raw(h_m);
    p0_vs   = vs_raw(v_m);
    p0_mark = (h_m == 5 && v_m == 0);

    @(negedge clk);
    n_cyc++;
    if (h_m == HT - 1) begin
      h_m = 0;
      v_m = (v_m == VT - 1) ? 0 : v_m + 1;
    end else begin
      h_m = h_m + 1;
    end
  endtask

  initial begin
    mode_f = 1'b0;
    #1 reset = 1'b1;
    {Red_level, Green_level, Blue_level} = 12'hFFF;
    {red0, green0, blue0} = 12'hFFF;
    repeat (3) @(negedge clk);
    check_reset("por");

    // Frame 1: pattern colours, one startOfFrame at (0, VA).
    reset = 1'b0;
    reinit();
    clear_stats();
    repeat (HT * VT) do_cycle();
    check("frame1_sof_cnt", 32'(sof_cnt), 32'd1);
    check("frame1_sof_at", 32'(sof_at), 32'(VA * HT));
    check("frame1_wrap_x", 32'(pixelX), 32'd0);
    check("frame1_wrap_y", 32'(pixelY), 32'd0);

    // Frame 2: constant full-scale colour; measure active area and sync widths.
    mode_f = 1'b1;
    clear_stats();
    repeat (HT * VT) do_cycle();
    check("frame2_full", 32'(full_cnt), 32'(HA * VA));
    check("frame2_hs_low", 32'(hs_low), 32'(HS * VT));
    check("frame2_vs_low", 32'(vs_low), 32'(VS * HT));
    check("frame2_sof_cnt", 32'(sof_cnt), 32'd1);

    // Mid-frame asynchronous reset in the active area.
    mode_f = 1'b0;
    while (!(h_m == 10 && v_m == 5)) do_cycle();
    #2 reset = 1'b1;
    #1 check_reset("async");
    repeat (5) begin
      @(negedge clk);
      check_reset("hold");
    end
    reset = 1'b0;
    reinit();
    clear_stats();
    repeat (2 * HT) do_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
